// File: rtl/frame_scanout.sv
// frame_scanout
// 160x120x3-bit frame buffer with a pixel-plot write port and a 640x480
// VGA scanout (4x4 pixel replication). After reset the whole buffer is
// cleared to black, one word per clk, with busy held high. Plot requests
// are ignored during the clear. Scanout runs the whole time, but it shows
// black until the clear has finished.
//
// Ports
//   clk          in   system clock (50 MHz)
//   reset        in   synchronous reset, active-high
//   x, y         in   plot coordinates, column 0..159 and row 0..119
//   colour       in   plot colour {R,G,B}
//   plot         in   write strobe, sampled on every clk edge
//   busy         out  high while the buffer is being cleared
//   vga_clk      out  25 MHz pixel clock (the pixel-enable toggle)
//   vga_hs/vs    out  active-low syncs
//   vga_blank_n  out  low outside the visible area
//   vga_sync_n   out  tied low
//   vga_r/g/b    out  1-bit channel replicated to 10 bits
//   frame_done   out  1-clk pulse when the counters wrap to (0,0)
//
// The timing parameters default to standard 640x480@60. They are exposed
// so that the vertical frame can be shortened when a short frame is useful.
module frame_scanout #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] colour,
  input  logic       plot,
  output logic       busy,
  output logic       vga_clk,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_sync_n,
  output logic [9:0] vga_r,
  output logic [9:0] vga_g,
  output logic [9:0] vga_b,
  output logic       frame_done
);

  localparam int H_TOT    = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT    = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HW       = $clog2(H_TOT);
  localparam int VW       = $clog2(V_TOT);
  localparam int FB_WORDS = 160 * 120;
  localparam int AW       = 15;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_VEND = HW'(H_VIS);
  localparam logic [HW-1:0] H_SST  = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] H_SEND = HW'(H_VIS + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_VEND = VW'(V_VIS);
  localparam logic [VW-1:0] V_SST  = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] V_SEND = VW'(V_VIS + V_FP + V_SYNC);
  localparam logic [AW-1:0] C_LAST = AW'(FB_WORDS - 1);

  typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

  // Control / clear state
  state_t          r_state;
  logic            r_busy;
  logic [AW-1:0]   r_caddr;

  // Raster timing
  logic            r_tog;
  logic [HW-1:0]   r_h;
  logic [VW-1:0]   r_v;
  logic            r_fd;

  // Frame buffer
  logic [2:0]      r_mem [0:FB_WORDS-1];
  logic [2:0]      r_rdata;

  // Pipeline stage 1 (aligned with the buffer read) and stage 2 (outputs)
  logic            r_hs1, r_vs1, r_bl1, r_clr1;
  logic            r_hs, r_vs, r_bl;
  logic [2:0]      r_rgb;

  logic            w_we;
  logic [AW-1:0]   w_waddr, w_paddr, w_raddr, w_rrow;
  logic [2:0]      w_wdata;
  logic            w_hvis, w_vvis, w_hsync, w_vsync, w_inrange;

  // y*160 + x as y*128 + y*32 + x
  assign w_paddr   = AW'({y, 7'b0}) + AW'({y, 5'b0}) + AW'(x);
  // Range check on the raw coordinates, so an oversized x can never spill
  // into the next row.
  assign w_inrange = (x < 8'd160) && (y < 7'd120);

  assign w_hvis  = (r_h < H_VEND);
  assign w_vvis  = (r_v < V_VEND);
  assign w_hsync = (r_h >= H_SST) && (r_h < H_SEND);
  assign w_vsync = (r_v >= V_SST) && (r_v < V_SEND);

  // Outside the visible area the counters would point past the buffer, so
  // the read is parked on word 0. The pixel is blanked there anyway.
  assign w_rrow  = AW'(r_v >> 2);
  assign w_raddr = (w_hvis && w_vvis) ? ((w_rrow << 7) + (w_rrow << 5) + AW'(r_h >> 2))
                                      : '0;

  // Single write port: the clear sweep owns it in CLEAR, plots own it in RUN.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    if (!reset) begin
      if (r_state == S_CLEAR) begin
        w_we    = 1'b1;
        w_waddr = r_caddr;
      end else if (plot && !r_busy && w_inrange) begin
        w_we    = 1'b1;
        w_waddr = w_paddr;
        w_wdata = colour;
      end
    end
  end

  // Read-before-write: a same-address read on a write edge returns old data.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
    r_rdata <= r_mem[w_raddr];
  end

  // Clear sequencer. busy drops on the edge that writes the last word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_CLEAR;
      r_busy  <= 1'b1;
      r_caddr <= '0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          if (r_caddr == C_LAST) begin
            r_state <= S_RUN;
            r_busy  <= 1'b0;
          end else begin
            r_caddr <= r_caddr + 1'b1;
          end
        end
        S_RUN:   r_busy <= 1'b0;
        default: r_state <= S_CLEAR;
      endcase
    end
  end

  // Pixel enable toggles every clk. The counters step on the clks where it
  // is high, so one pixel lasts two clks.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tog <= 1'b0;
      r_h   <= '0;
      r_v   <= '0;
      r_fd  <= 1'b0;
    end else begin
      r_tog <= ~r_tog;
      r_fd  <= 1'b0;
      if (r_tog) begin
        if (r_h == H_LAST) begin
          r_h <= '0;
          if (r_v == V_LAST) begin
            r_v  <= '0;
            r_fd <= 1'b1;
          end else begin
            r_v <= r_v + 1'b1;
          end
        end else begin
          r_h <= r_h + 1'b1;
        end
      end
    end
  end

  // Syncs and blank go through two registers so that they line up with the
  // read data, which already spends one clk in the buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hs1  <= 1'b1;
      r_vs1  <= 1'b1;
      r_bl1  <= 1'b0;
      r_clr1 <= 1'b1;
      r_hs   <= 1'b1;
      r_vs   <= 1'b1;
      r_bl   <= 1'b0;
      r_rgb  <= '0;
    end else begin
      r_hs1  <= ~w_hsync;
      r_vs1  <= ~w_vsync;
      r_bl1  <= w_hvis && w_vvis;
      r_clr1 <= (r_state == S_CLEAR);
      r_hs   <= r_hs1;
      r_vs   <= r_vs1;
      r_bl   <= r_bl1;
      // During the clear the buffer holds stale or undefined data, so it is
      // shown as black.
      r_rgb  <= (r_bl1 && !r_clr1) ? r_rdata : 3'b000;
    end
  end

  assign busy        = r_busy;
  assign vga_clk     = r_tog;
  assign vga_hs      = r_hs;
  assign vga_vs      = r_vs;
  assign vga_blank_n = r_bl;
  assign vga_sync_n  = 1'b0;
  assign vga_r       = {10{r_rgb[2]}};
  assign vga_g       = {10{r_rgb[1]}};
  assign vga_b       = {10{r_rgb[0]}};
  assign frame_done  = r_fd;

endmodule
